// File: rtl/bit_ext_16b_to_32b_pipe_if.sv
// Stream bus for the Q4.12 -> Q8.24 widener.
// Input side is a valid/ready sample stream; output carries frame tags.
interface bit_ext_16b_to_32b_pipe_if #(
  parameter int IDX_W = 6
);
  logic             i_valid;
  logic             i_ready;
  logic [15:0]      i_data;
  logic             i_flush;
  logic             o_valid;
  logic             o_ready;
  logic [31:0]      o_data;
  logic [IDX_W-1:0] o_index;
  logic             o_last;

  modport master (
    output i_valid, i_data, i_flush, o_ready,
    input  i_ready, o_valid, o_data, o_index, o_last
  );

  modport slave (
    input  i_valid, i_data, i_flush, o_ready,
    output i_ready, o_valid, o_data, o_index, o_last
  );
endinterface

// File: rtl/bit_ext_16b_to_32b_pipe.sv
// Q4.12 -> Q8.24 sample widener with a 2-entry skid buffer
// and per-sample frame index/last tags.
module bit_ext_16b_to_32b_pipe #(
  parameter int FRAME_LEN = 64,
  parameter int IDX_W     = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  bit_ext_16b_to_32b_pipe_if.slave   bus
);

  typedef struct packed {
    logic [31:0]      data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } ent_t;

  ent_t             main_q, main_d;
  ent_t             skid_q, skid_d;
  ent_t             new_e;
  logic             main_vld_q, main_vld_d;
  logic             skid_full_q, skid_full_d;
  logic             rdy_q;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_cur;
  logic             in_fire;
  logic             out_fire;
  logic             main_free;

  always_comb begin
    idx_cur     = bus.i_flush ? '0 : cnt_q;
    new_e.data  = {{4{bus.i_data[15]}}, bus.i_data, 12'h000};
    new_e.idx   = idx_cur;
    new_e.last  = (idx_cur == IDX_W'(FRAME_LEN - 1));
    in_fire     = bus.i_valid & rdy_q;
    out_fire    = main_vld_q & bus.o_ready;
    main_free   = ~main_vld_q | out_fire;

    main_d      = main_q;
    main_vld_d  = main_vld_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    cnt_d       = cnt_q;

    if (in_fire)
      cnt_d = new_e.last ? '0 : idx_cur + IDX_W'(1);
    else if (bus.i_flush)
      cnt_d = '0;

    // i_ready is ~skid_full, so no input can arrive while skid is full
    unique case (1'b1)
      main_free & skid_full_q: begin
        main_d      = skid_q;
        main_vld_d  = 1'b1;
        skid_full_d = 1'b0;
      end
      main_free & ~skid_full_q & in_fire: begin
        main_d     = new_e;
        main_vld_d = 1'b1;
      end
      main_free & ~skid_full_q & ~in_fire: begin
        main_vld_d = 1'b0;
      end
      ~main_free & in_fire: begin
        skid_d      = new_e;
        skid_full_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q      <= '0;
      skid_q      <= '0;
      main_vld_q  <= 1'b0;
      skid_full_q <= 1'b0;
      rdy_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      main_vld_q  <= main_vld_d;
      skid_full_q <= skid_full_d;
      rdy_q       <= ~skid_full_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.i_ready = rdy_q;
  assign bus.o_valid = main_vld_q;
  assign bus.o_data  = main_q.data;
  assign bus.o_index = main_q.idx;
  assign bus.o_last  = main_q.last;

endmodule
